// File: rtl/uart_rx_param_if.sv
// Receive-side handshake bundle for uart_rx_param.
//   master : the receiver. It drives the held word, its valid flag, its error sidebands
//            and the overrun pulse, and it samples data_ready.
//   slave  : the consumer. It samples everything above and drives data_ready.
//   data_rx     word held in the receiver's holding register
//   data_valid  holding register full
//   data_ready  consumer accepts on data_valid & data_ready
//   parity_err  parity mismatch of the held word
//   frame_err   stop bit of the held word was sampled 0
//   overrun_err one-cycle pulse: a finished frame was dropped because the register was full
interface uart_rx_param_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] data_rx;
   logic                 data_valid;
   logic                 data_ready;
   logic                 parity_err;
   logic                 frame_err;
   logic                 overrun_err;

   modport master (
      output data_rx,
      output data_valid,
      output parity_err,
      output frame_err,
      output overrun_err,
      input  data_ready
   );

   modport slave (
      input  data_rx,
      input  data_valid,
      input  parity_err,
      input  frame_err,
      input  overrun_err,
      output data_ready
   );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised asynchronous serial receiver.
// It synchronises rx, detects a start bit and rejects start glitches. Each bit is a
// 3-sample majority vote around the bit centre. Received words and their parity and
// framing flags go into a one-entry holding register that is emptied over a
// valid/ready handshake.
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   rx       serial line, idle high, asynchronous to clk
//   rx_busy  high from start detection until the receiver is back in IDLE
//   bus      uart_rx_param_if.master: data_rx, data_valid, data_ready,
//            parity_err, frame_err, overrun_err
module uart_rx_param #(
   parameter int CLKS_PER_BIT = 5208,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            rx,
   output logic            rx_busy,
   uart_rx_param_if.master bus
);

   localparam int CW  = $clog2(CLKS_PER_BIT);
   localparam int BW  = $clog2(DATA_BITS);
   localparam int MID = CLKS_PER_BIT / 2;

   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] MID_M1   = CW'(MID - 1);
   localparam logic [CW-1:0] MID_C    = CW'(MID);
   localparam logic [CW-1:0] MID_P1   = CW'(MID + 1);
   localparam logic [BW-1:0] BIT_ZERO = {BW{1'b0}};
   localparam logic [BW-1:0] BIT_ONE  = BW'(1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4,
      ST_BREAK  = 3'd5
   } state_t;

   // 2-of-3 majority of the samples taken around the bit centre
   function automatic logic majority3(input logic a, input logic b, input logic c);
      majority3 = (a & b) | (a & c) | (b & c);
   endfunction

   // Parity check of data plus received parity bit; odd mode wants an odd count of ones
   function automatic logic parity_error(input logic [DATA_BITS-1:0] d, input logic p);
      logic ones_odd;
      ones_odd = ^{d, p};
      if (PARITY == 1) begin
         parity_error = ~ones_odd;
      end else if (PARITY == 2) begin
         parity_error = ones_odd;
      end else begin
         parity_error = 1'b0;
      end
   endfunction

   logic                 rx_meta_q;
   logic                 rx_s_q;
   state_t               state_q;
   logic [CW-1:0]        cnt_q;
   logic [BW-1:0]        bit_idx_q;
   logic                 smp0_q;
   logic                 smp1_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 par_err_q;
   logic [DATA_BITS-1:0] data_q;
   logic                 data_valid_q;
   logic                 perr_q;
   logic                 ferr_q;
   logic                 overrun_q;
   logic                 busy_q;

   logic                 vote_d;
   logic                 at_dec_d;
   logic                 at_end_d;
   logic [CW-1:0]        cnt_inc_d;
   logic                 accept_d;
   logic                 can_load_d;

   // Two-flop synchroniser; both stages reset high so reset never looks like a start bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   // Bit vote, counter landmarks and holding-register handshake terms
   always_comb begin
      vote_d     = majority3(smp0_q, smp1_q, rx_s_q);
      at_dec_d   = (cnt_q == MID_P1);
      at_end_d   = (cnt_q == CNT_LAST);
      cnt_inc_d  = cnt_q + CNT_ONE;
      accept_d   = data_valid_q & bus.data_ready;
      // The register can take a new word when it is empty or is being emptied this cycle
      can_load_d = ~data_valid_q | bus.data_ready;
   end

   // Receive FSM with bit timing, shifting, error detection and the holding register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= CNT_ZERO;
         bit_idx_q    <= BIT_ZERO;
         smp0_q       <= 1'b1;
         smp1_q       <= 1'b1;
         shift_q      <= {DATA_BITS{1'b0}};
         par_err_q    <= 1'b0;
         data_q       <= {DATA_BITS{1'b0}};
         data_valid_q <= 1'b0;
         perr_q       <= 1'b0;
         ferr_q       <= 1'b0;
         overrun_q    <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         overrun_q <= 1'b0;
         // A load at the stop decision below overrides this clear
         if (accept_d) begin
            data_valid_q <= 1'b0;
         end
         // The first two vote samples are latched; the third is rx_s at the decision count
         if (cnt_q == MID_M1) begin
            smp0_q <= rx_s_q;
         end
         if (cnt_q == MID_C) begin
            smp1_q <= rx_s_q;
         end

         case (state_q)
            ST_IDLE: begin
               cnt_q     <= CNT_ZERO;
               bit_idx_q <= BIT_ZERO;
               if (!rx_s_q) begin
                  par_err_q <= 1'b0;
                  busy_q    <= 1'b1;
                  state_q   <= ST_START;
               end
            end

            ST_START: begin
               if (at_dec_d && vote_d) begin
                  // Line came back high before the bit centre: a glitch, not a frame
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end else if (at_end_d) begin
                  cnt_q   <= CNT_ZERO;
                  state_q <= ST_DATA;
               end else begin
                  cnt_q <= cnt_inc_d;
               end
            end

            ST_DATA: begin
               if (at_dec_d) begin
                  shift_q <= {vote_d, shift_q[DATA_BITS-1:1]};
               end
               if (at_end_d) begin
                  cnt_q <= CNT_ZERO;
                  if (bit_idx_q == BIT_LAST) begin
                     bit_idx_q <= BIT_ZERO;
                     state_q   <= (PARITY != 0) ? ST_PARITY : ST_STOP;
                  end else begin
                     bit_idx_q <= bit_idx_q + BIT_ONE;
                  end
               end else begin
                  cnt_q <= cnt_inc_d;
               end
            end

            ST_PARITY: begin
               if (at_dec_d) begin
                  par_err_q <= parity_error(shift_q, vote_d);
               end
               if (at_end_d) begin
                  cnt_q   <= CNT_ZERO;
                  state_q <= ST_STOP;
               end else begin
                  cnt_q <= cnt_inc_d;
               end
            end

            ST_STOP: begin
               // Decide at the vote point so the receiver is ready before the next start edge
               if (at_dec_d) begin
                  if (can_load_d) begin
                     data_q       <= shift_q;
                     perr_q       <= par_err_q;
                     ferr_q       <= ~vote_d;
                     data_valid_q <= 1'b1;
                  end else begin
                     overrun_q <= 1'b1;
                  end
                  if (vote_d) begin
                     busy_q  <= 1'b0;
                     state_q <= ST_IDLE;
                  end else begin
                     state_q <= ST_BREAK;
                  end
               end else begin
                  cnt_q <= cnt_inc_d;
               end
            end

            ST_BREAK: begin
               // Stay here while the line is held low so a break cannot restart a frame
               if (rx_s_q) begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end

            default: begin
               busy_q  <= 1'b0;
               cnt_q   <= CNT_ZERO;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.data_rx     = data_q;
   assign bus.data_valid  = data_valid_q;
   assign bus.parity_err  = perr_q;
   assign bus.frame_err   = ferr_q;
   assign bus.overrun_err = overrun_q;
   assign rx_busy         = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: three instances with different widths and
// parity modes, directed scenarios on instance 0, and a randomised run on all three.
module tb_uart_rx_param;

   typedef struct packed {
      logic [8:0] data;
      logic       perr;
      logic       ferr;
   } exp_t;

   logic       clk     = 1'b0;
   logic       rst_n   = 1'b0;
   logic [2:0] rx_v    = 3'b111;
   logic [2:0] rdy_v   = 3'b111;
   logic       abort_a = 1'b0;
   logic       busy_a;
   logic       busy_b;
   logic       busy_c;

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];
   int   ovr_exp[3];
   int   ovr_seen[3];
   int   total_cnt = 0;
   int   pass_cnt  = 0;

   always #5 clk = ~clk;

   uart_rx_param_if #(.DATA_BITS(8)) if_a ();
   uart_rx_param_if #(.DATA_BITS(7)) if_b ();
   uart_rx_param_if #(.DATA_BITS(5)) if_c ();

   assign if_a.data_ready = rdy_v[0];
   assign if_b.data_ready = rdy_v[1];
   assign if_c.data_ready = rdy_v[2];

   uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .rx(rx_v[0]), .rx_busy(busy_a), .bus(if_a.master));
   uart_rx_param #(.CLKS_PER_BIT(12), .DATA_BITS(7), .PARITY(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .rx(rx_v[1]), .rx_busy(busy_b), .bus(if_b.master));
   uart_rx_param #(.CLKS_PER_BIT(10), .DATA_BITS(5), .PARITY(2)) dut_c (
      .clk(clk), .rst_n(rst_n), .rx(rx_v[2]), .rx_busy(busy_c), .bus(if_c.master));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total_cnt++;
      if (act === req) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   // Inputs change 2 ns after the rising edge; outputs are sampled on the falling edge
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic push_exp(input int k, input exp_t e);
      case (k)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   function automatic int q_size(input int k);
      case (k)
         0:       return q0.size();
         1:       return q1.size();
         default: return q2.size();
      endcase
   endfunction

   task automatic mon_word(input int k, input logic [8:0] d, input logic pe, input logic fe);
      exp_t e;
      if (q_size(k) == 0) begin
         check($sformatf("spurious_word_inst%0d_depth", k), 32'd0, 32'd1);
      end else begin
         case (k)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
         endcase
         check($sformatf("data_inst%0d", k),       {23'd0, d},  {23'd0, e.data});
         check($sformatf("parity_err_inst%0d", k), {31'd0, pe}, {31'd0, e.perr});
         check($sformatf("frame_err_inst%0d", k),  {31'd0, fe}, {31'd0, e.ferr});
      end
   endtask

   // Scoreboard monitors: each accepted word is compared with the oldest expectation
   always @(negedge clk) begin
      if (rst_n) begin
         if (if_a.overrun_err) ovr_seen[0]++;
         if (if_a.data_valid && if_a.data_ready)
            mon_word(0, {1'b0, if_a.data_rx}, if_a.parity_err, if_a.frame_err);
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (if_b.overrun_err) ovr_seen[1]++;
         if (if_b.data_valid && if_b.data_ready)
            mon_word(1, {2'b0, if_b.data_rx}, if_b.parity_err, if_b.frame_err);
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (if_c.overrun_err) ovr_seen[2]++;
         if (if_c.data_valid && if_c.data_ready)
            mon_word(2, {4'b0, if_c.data_rx}, if_c.parity_err, if_c.frame_err);
      end
   end

   // Drive one frame on line k. Optionally flips one cycle at the centre of bit gbit
   // (majority voting must hide it). With stop=0 the line is left low for hold_bits
   // extra bit times and the caller raises it. The expectation is decided at the start
   // of the stop bit: a word is dropped (overrun) when one is still held and ready is low.
   task automatic send_frame(input int k, input int cpb, input int db, input int pm,
                             input logic [8:0] d, input logic pbit, input logic stop,
                             input int gbit, input int hold_bits);
      logic [11:0] bits;
      logic [8:0]  dm;
      logic        good_p;
      int          nb;
      exp_t        e;
      dm = d & ((9'd1 << db) - 9'd1);
      nb = 0;
      bits = 12'hFFF;
      bits[nb] = 1'b0; nb++;
      for (int i = 0; i < db; i++) begin
         bits[nb] = dm[i]; nb++;
      end
      if (pm != 0) begin
         bits[nb] = pbit; nb++;
      end
      bits[nb] = stop; nb++;
      // Correct parity bit: odd mode makes the total count of ones odd, even mode even
      good_p = (pm == 1) ? ~(^dm) : (^dm);
      e.data = dm;
      e.perr = (pm != 0) && (pbit != good_p);
      e.ferr = ~stop;
      for (int j = 0; j < nb; j++) begin
         if (j == nb - 1) begin
            if (q_size(k) != 0 && rdy_v[k] == 1'b0) ovr_exp[k]++;
            else push_exp(k, e);
         end
         for (int c = 0; c < cpb; c++) begin
            if (k == 0 && abort_a) begin
               rx_v[k] = 1'b1;
               return;
            end
            rx_v[k] = bits[j] ^ ((j == gbit && c == cpb / 2 + 1) ? 1'b1 : 1'b0);
            tick();
         end
      end
      if (!stop) begin
         repeat (hold_bits * cpb) tick();
      end
   endtask

   task automatic rand_run(input int k, input int cpb, input int db, input int pm, input int n);
      logic [8:0] d;
      logic       p;
      logic       s;
      int         g;
      for (int i = 0; i < n; i++) begin
         d = 9'($urandom_range(0, 511));
         p = 1'($urandom_range(0, 1));
         s = ($urandom_range(0, 3) != 0);
         g = $urandom_range(0, db + 4);
         send_frame(k, cpb, db, pm, d, p, s, g, 1);
         rx_v[k] = 1'b1;
         repeat ($urandom_range(4, 9)) tick();
      end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ovr_base;

      // Reset state
      rst_n = 1'b0;
      repeat (3) tick();
      check("rst_data_rx",    {24'd0, if_a.data_rx},    32'd0);
      check("rst_data_valid", {31'd0, if_a.data_valid}, 32'd0);
      check("rst_parity_err", {31'd0, if_a.parity_err}, 32'd0);
      check("rst_frame_err",  {31'd0, if_a.frame_err},  32'd0);
      check("rst_overrun",    {31'd0, if_a.overrun_err}, 32'd0);
      check("rst_busy",       {31'd0, busy_a},          32'd0);
      rst_n = 1'b1;
      repeat (5) tick();

      // Clean word, wrong parity, then the same word with correct parity
      send_frame(0, 16, 8, 1, 9'h0A5, 1'b1, 1'b1, -1, 0); repeat (5) tick();
      send_frame(0, 16, 8, 1, 9'h03C, 1'b0, 1'b1, -1, 0); repeat (5) tick();
      send_frame(0, 16, 8, 1, 9'h03C, 1'b1, 1'b1, -1, 0); repeat (5) tick();

      // Stop bit 0 followed by a long low: busy must persist until the line rises
      send_frame(0, 16, 8, 1, 9'h055, 1'b1, 1'b0, -1, 3);
      check("busy_held_in_break", {31'd0, busy_a}, 32'd1);
      rx_v[0] = 1'b1;
      repeat (6) tick();
      check("busy_after_break", {31'd0, busy_a}, 32'd0);
      send_frame(0, 16, 8, 1, 9'h012, 1'b1, 1'b1, -1, 0); repeat (5) tick();

      // Short low pulse from idle is a start glitch
      rx_v[0] = 1'b0;
      repeat (3) tick();
      rx_v[0] = 1'b1;
      check("glitch_busy_rise", {31'd0, busy_a}, 32'd1);
      repeat (16) tick();
      check("glitch_busy_fall", {31'd0, busy_a}, 32'd0);
      check("glitch_no_word", q_size(0), 32'd0);

      // Holding register full: second word is dropped with one overrun pulse
      rdy_v[0] = 1'b0;
      ovr_base = ovr_seen[0];
      send_frame(0, 16, 8, 1, 9'h011, 1'b1, 1'b1, -1, 0); repeat (5) tick();
      send_frame(0, 16, 8, 1, 9'h022, 1'b1, 1'b1, -1, 0); repeat (5) tick();
      check("held_valid",   {31'd0, if_a.data_valid}, 32'd1);
      check("held_data",    {24'd0, if_a.data_rx},    32'h11);
      check("overrun_once", ovr_seen[0] - ovr_base,   32'd1);
      rdy_v[0] = 1'b1;
      repeat (2) tick();
      check("valid_after_accept", {31'd0, if_a.data_valid}, 32'd0);

      // Reset during data bit 4 of 0x7E, then a fresh 0x7E
      fork
         send_frame(0, 16, 8, 1, 9'h07E, 1'b1, 1'b1, -1, 0);
         begin
            repeat (5 * 16 + 8) tick();
            rst_n = 1'b0;
            #1;
            check("midrst_busy",    {31'd0, busy_a},          32'd0);
            check("midrst_data_rx", {24'd0, if_a.data_rx},    32'd0);
            check("midrst_valid",   {31'd0, if_a.data_valid}, 32'd0);
            check("midrst_overrun", {31'd0, if_a.overrun_err}, 32'd0);
            abort_a = 1'b1;
            repeat (3) tick();
            rst_n = 1'b1;
         end
      join
      abort_a = 1'b0;
      repeat (5) tick();
      send_frame(0, 16, 8, 1, 9'h07E, 1'b1, 1'b1, -1, 0); repeat (5) tick();

      // No-parity 7-bit instance: 0x41
      send_frame(1, 12, 7, 0, 9'h041, 1'b0, 1'b1, -1, 0); repeat (5) tick();

      // Randomised frames on all three instances in parallel
      fork
         rand_run(0, 16, 8, 1, 14);
         rand_run(1, 12, 7, 0, 14);
         rand_run(2, 10, 5, 2, 14);
      join
      repeat (40) tick();

      for (int k = 0; k < 3; k++) begin
         check($sformatf("pending_words_inst%0d", k), q_size(k), 32'd0);
         check($sformatf("overrun_count_inst%0d", k), ovr_seen[k], ovr_exp[k]);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
